data_memory_lsu: RTL and testbench

- Parametrised successor to the single-cycle byte-array data memory.
- Adds RISC-V sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), byte-lane write enables and sign/zero extension.
- Adds a valid/ready request handshake with a configurable read latency (modelling slow memory/cache), plus misalignment detection.
- Sits between the pipeline MEM stage and the byte-organised RAM array; the pipeline stalls on !req_ready.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_byte_ram.sv | 25 ++
 rtl/data_memory_lsu.sv | 151 +++++++++++++++
 tb/tb_data_memory_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: funct3 encodings, FSM states
// and the lane-mask / load-extension helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Low two funct3 bits encode access size for both loads and stores.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   byte_mask = 4'b0001 << off;
      2'b01:   byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic req_error(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: req_error = 1'b0;
      F3_H, F3_HU: req_error = off[0];
      F3_W:        req_error = (off != 2'b00);
      default:     req_error = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_extend = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_extend = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_extend = {24'b0, shifted[7:0]};
      F3_HU:   load_extend = {16'b0, shifted[15:0]};
      default: load_extend = shifted;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module dmem_byte_ram #(
  parameter int WORD_AW = 15
) (
  input  logic               clk_i,
  input  logic [3:0]         we_i,
  input  logic [WORD_AW-1:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [0:(2**WORD_AW)-1];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_lsu.sv
// RV32 load/store unit in front of a byte RAM: valid/ready handshake, sub-word
// access, misalignment errors. Optional perf counters under DMEM_PERF_COUNT_EN.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 17,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
`ifdef DMEM_PERF_COUNT_EN
  ,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_errors
`endif
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  reqErr;
  logic [3:0]            ramWe;
  logic [31:0]           ramRdata;
  logic [31:0]           wdataLanes;

  assign reqErr     = req_error(req_funct3, req_addr[1:0]);
  assign wdataLanes = req_wdata << {req_addr[1:0], 3'b000};

  dmem_byte_ram #(
    .WORD_AW(ADDR_WIDTH - 2)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ramWe),
    .addr_i (req_addr[ADDR_WIDTH-1:2]),
    .wdata_i(wdataLanes),
    .rdata_o(ramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // WAIT lasts latency-1 cycles for loads and WRITE_LATENCY cycles for stores,
  // so RESP lands READ_LATENCY / WRITE_LATENCY+1 cycles after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ramWe   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d   = reqErr;
          rdata_d = (reqErr || req_we) ? '0 : load_extend(req_funct3, ramRdata, req_addr[1:0]);
          if (reqErr) begin
            state_d = RESP;
          end else if (req_we) begin
            ramWe = byte_mask(req_funct3, req_addr[1:0]);
            if (WRITE_LATENCY == 0) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = 3'(WRITE_LATENCY - 1);
            end
          end else if (READ_LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(READ_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

`ifdef DMEM_PERF_COUNT_EN
  logic        we_q;
  logic [31:0] loads_q, stores_q, errors_q;

  // Kind of the in-flight request is remembered so the response can be classified.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        we_q <= req_we;
      end
      if (resp_valid) begin
        if (err_q) begin
          if (errors_q != '1) errors_q <= errors_q + 32'd1;
        end else if (we_q) begin
          if (stores_q != '1) stores_q <= stores_q + 32'd1;
        end else begin
          if (loads_q != '1) loads_q <= loads_q + 32'd1;
        end
      end
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errors = errors_q;
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: a byte-array reference model predicts each
// response, a negedge monitor pops and compares data, error flag, latency and ready.
module tb_data_memory_lsu;

  localparam int AW       = 17;
  localparam int RL       = 3;
  localparam int WL       = 1;
  localparam int MEM_SIZE = 2 ** AW;

  localparam logic [2:0] FB  = 3'b000;
  localparam logic [2:0] FH  = 3'b001;
  localparam logic [2:0] FW  = 3'b010;
  localparam logic [2:0] FBU = 3'b100;
  localparam logic [2:0] FHU = 3'b101;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
`ifdef DMEM_PERF_COUNT_EN
  logic [31:0]   perf_loads, perf_stores, perf_errors;
  int            expLoads = 0, expStores = 0, expErrors = 0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          issueCycle;
    int          kind;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  modelMem [int];
  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycleCount  = 0;

  data_memory_lsu #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
`ifdef DMEM_PERF_COUNT_EN
    ,
    .perf_loads (perf_loads),
    .perf_stores(perf_stores),
    .perf_errors(perf_errors)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Reference model: byte-addressed memory, size from funct3, alignment by modulo.
  function automatic exp_t modelRequest(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                                        input logic [31:0] wdata, input int c);
    exp_t        e;
    int          size;
    logic        bad;
    logic [31:0] word;
    e.issueCycle = c;
    e.rdata      = 32'd0;
    e.err        = 1'b0;
    case (f3)
      FB, FBU: size = 1;
      FH, FHU: size = 2;
      FW:      size = 4;
      default: size = 0;
    endcase
    bad = (size == 0) ? 1'b1 : ((int'(addr) % size) != 0);
    if (bad) begin
      e.err  = 1'b1;
      e.lat  = 1;
      e.kind = 2;
    end else if (we) begin
      for (int k = 0; k < size; k++) modelMem[(int'(addr) + k) % MEM_SIZE] = wdata[8*k +: 8];
      e.lat  = WL + 1;
      e.kind = 1;
    end else begin
      word = 32'd0;
      for (int k = 0; k < size; k++) word[8*k +: 8] = modelMem[(int'(addr) + k) % MEM_SIZE];
      if (f3 == FB && word[7])  word = word | 32'hFFFF_FF00;
      if (f3 == FH && word[15]) word = word | 32'hFFFF_0000;
      e.rdata = word;
      e.lat   = RL;
      e.kind  = 0;
    end
    return e;
  endfunction

  // Waits (bounded) for req_ready, presents one request for exactly one accepting edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                               input logic [31:0] wdata);
    exp_t e;
    int   waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, waited);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e = modelRequest(we, f3, addr, wdata, cycleCount);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    expQ.delete();
`ifdef DMEM_PERF_COUNT_EN
    expLoads  = 0;
    expStores = 0;
    expErrors = 0;
`endif
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Monitor: ready must be low exactly while a request is outstanding; each
  // resp_valid pulse is matched against the oldest expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst !== 1'b1) begin
      checkOutput("req_ready", {31'b0, req_ready}, {31'b0, (expQ.size() == 0)});
      if (resp_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_resp: resp_valid=1 with no request outstanding, expected 0");
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          checkOutput("latency", 32'(cycleCount - e.issueCycle), 32'(e.lat));
`ifdef DMEM_PERF_COUNT_EN
          if (e.kind == 0) expLoads++;
          else if (e.kind == 1) expStores++;
          else expErrors++;
`endif
        end
      end
    end
  end

  logic [2:0] storeF3 [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

  initial begin
    int waited;
    logic       rw;
    logic [2:0] f3;

    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'd0;
    rst        = 1'b1;
    #1;
    applyReset(3);

    @(negedge clk);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_err", {31'b0, resp_err}, 32'd0);
    @(posedge clk);
    #1;

    // Word store/load, then byte and halfword lanes with extension.
    applyStimulus(1'b1, FW, 17'h100, 32'hDEAD_BEEF);
    applyStimulus(1'b0, FW, 17'h100, 32'd0);
    applyStimulus(1'b1, FB, 17'h101, 32'h0000_0080);
    applyStimulus(1'b0, FB, 17'h101, 32'd0);
    applyStimulus(1'b0, FBU, 17'h101, 32'd0);
    applyStimulus(1'b0, FW, 17'h100, 32'd0);
    applyStimulus(1'b1, FW, 17'h200, 32'h1122_3344);
    applyStimulus(1'b1, FH, 17'h202, 32'h0000_8001);
    applyStimulus(1'b0, FH, 17'h202, 32'd0);
    applyStimulus(1'b0, FHU, 17'h202, 32'd0);

    // Errors must not write; the following word read shows 0x200 unchanged.
    applyStimulus(1'b0, FW, 17'h103, 32'd0);
    applyStimulus(1'b1, FH, 17'h205, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'b011, 17'h200, 32'hFFFF_FFFF);
    applyStimulus(1'b0, FW, 17'h200, 32'd0);

    // Top word of the address space.
    applyStimulus(1'b1, FW, 17'h1FFFC, 32'hCAFE_F00D);
    applyStimulus(1'b0, FH, 17'h1FFFE, 32'd0);

    // Reset while a load sits in WAIT: its response must never appear.
    applyStimulus(1'b0, FW, 17'h100, 32'd0);
    @(posedge clk);
    #1;
    applyReset(2);
    @(negedge clk);
    checkOutput("ready_after_rst", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Randomised traffic in a window that is fully initialised first.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, FW, AW'(17'h300 + 4 * i), $urandom);
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      f3 = rw ? storeF3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      applyStimulus(rw, f3, AW'(17'h300 + $urandom_range(0, 63)), $urandom);
    end

    waited = 0;
    while (expQ.size() != 0 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", expQ.size());
    end

`ifdef DMEM_PERF_COUNT_EN
    @(negedge clk);
    checkOutput("perf_loads", perf_loads, 32'(expLoads));
    checkOutput("perf_stores", perf_stores, 32'(expStores));
    checkOutput("perf_errors", perf_errors, 32'(expErrors));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
